// File: rtl/pio_input_pkg.sv
// Shared register map and parameter sanity checks for the edge-capturing input PIO.
package pio_input_pkg;

  localparam int BUS_W = 32;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RAW  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_RISE = 3'd4;
  localparam logic [2:0] ADDR_FALL = 3'd5;
  localparam logic [2:0] ADDR_DEB  = 3'd6;

  // Every register must fit the 32-bit bus; two flops minimum for metastability.
  function automatic bit widths_ok(input int width, input int deb_w, input int sync_stages);
    return (width >= 1) && (width <= BUS_W) &&
           (deb_w >= 1) && (deb_w <= BUS_W) &&
           (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: synchroniser chain, saturating debounce counter and stable flop.
module pio_debounce_ch
  import pio_input_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic [DEB_W-1:0] deb_period,
  output logic             sync,
  output logic             stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_W-1:0]       cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A change is accepted once it has differed for deb_period+1 consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt >= deb_period) begin
      stable <= sync;
      cnt    <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO: debounced inputs, per-bit rise/fall edge capture (W1C) and masked level irq.
module pio_input_edge_irq
  import pio_input_pkg::*;
#(
  parameter int WIDTH          = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int DEB_W          = 16,
  parameter int DEB_PERIOD_RST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  if (!widths_ok(WIDTH, DEB_W, SYNC_STAGES)) begin : g_bad_params
    $error("pio_input_edge_irq: WIDTH/DEB_W must be 1..32 and SYNC_STAGES >= 2");
  end

  logic [WIDTH-1:0] sync_vec;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [DEB_W-1:0] deb_period;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .din       (in_port[i]),
      .deb_period(deb_period),
      .sync      (sync_vec[i]),
      .stable    (stable[i])
    );
  end

  assign wr           = chipselect & ~write_n;
  assign ev           = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
  assign w1c          = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      rise_en      <= '0;
      fall_en      <= '1;
      deb_period   <= DEB_W'(DEB_PERIOD_RST);
      irq          <= 1'b0;
    end else begin
      stable_d <= stable;
      // Set has priority over clear so an edge landing on a W1C cycle survives.
      edge_capture <= (edge_capture & ~w1c) | ev;
      irq          <= |(edge_capture & irq_mask);
      if (wr) begin
        case (address)
          ADDR_MASK: irq_mask   <= writedata[WIDTH-1:0];
          ADDR_RISE: rise_en    <= writedata[WIDTH-1:0];
          ADDR_FALL: fall_en    <= writedata[WIDTH-1:0];
          ADDR_DEB:  deb_period <= writedata[DEB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = stable;
      ADDR_RAW:  rd_next[WIDTH-1:0] = sync_vec;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      ADDR_RISE: rd_next[WIDTH-1:0] = rise_en;
      ADDR_FALL: rd_next[WIDTH-1:0] = fall_en;
      ADDR_DEB:  rd_next[DEB_W-1:0] = deb_period;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Directed bench for pio_input_edge_irq with a window-based behavioural model checked every cycle.
module tb_pio_input_edge_irq;

  localparam int W    = 5;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  pio_input_edge_irq #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEB_W(16), .DEB_PERIOD_RST(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Model state: what the outputs must be, derived from input history windows.
  logic [W-1:0]  din_hist[$];
  logic [W-1:0]  seen[$];
  logic [W-1:0]  m_sync, m_stable, m_stable_prev, m_edge, m_mask, m_rise, m_fall;
  logic [15:0]   m_deb;
  logic          m_irq;
  logic [31:0]   m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic model_step();
    logic [W-1:0]  n_stable, ev, clr;
    logic [31:0]   rd;
    bit            all_diff;
    if (reset) begin
      din_hist.delete();
      for (int k = 0; k < SYNC; k++) din_hist.push_front('0);
      seen.delete();
      m_sync = '0; m_stable = '0; m_stable_prev = '0; m_edge = '0;
      m_mask = '0; m_rise = '0; m_fall = '1; m_deb = 16'd0;
      m_irq = 1'b0; m_rd = '0;
      return;
    end
    // Debouncer sees the pre-edge synchronised value; accept if the last deb+1 samples all differ.
    seen.push_front(m_sync);
    if (seen.size() > 64) void'(seen.pop_back());
    n_stable = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = (seen.size() > int'(m_deb));
      if (all_diff)
        for (int j = 0; j <= int'(m_deb); j++)
          if (seen[j][b] == m_stable[b]) all_diff = 0;
      if (all_diff) n_stable[b] = ~m_stable[b];
    end
    ev = (m_stable & ~m_stable_prev & m_rise) | (~m_stable & m_stable_prev & m_fall);
    rd = '0;
    case (address)
      3'd0: rd = 32'(m_stable);
      3'd1: rd = 32'(m_sync);
      3'd2: rd = 32'(m_mask);
      3'd3: rd = 32'(m_edge);
      3'd4: rd = 32'(m_rise);
      3'd5: rd = 32'(m_fall);
      3'd6: rd = 32'(m_deb);
      default: rd = '0;
    endcase
    clr = '0;
    m_irq = |(m_edge & m_mask);
    if (chipselect && !write_n) begin
      case (address)
        3'd2: m_mask = writedata[W-1:0];
        3'd3: clr    = writedata[W-1:0];
        3'd4: m_rise = writedata[W-1:0];
        3'd5: m_fall = writedata[W-1:0];
        3'd6: m_deb  = writedata[15:0];
        default: ;
      endcase
    end
    m_edge = (m_edge & ~clr) | ev;
    m_stable_prev = m_stable;
    m_stable = n_stable;
    m_rd = rd;
    din_hist.push_front(in_port);
    void'(din_hist.pop_back());
    m_sync = din_hist[SYNC-1];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("rd_model", readdata, m_rd);
    check("irq_model", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic read_expect(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    tick();
    check(name, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    ticks(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;

    // Default configuration captures only the falling edge.
    in_port = 5'b00001; ticks(10);
    in_port = 5'b00000; ticks(10);
    read_expect(3'd3, 32'h01, "fall_capture");
    bus_write(3'd2, 32'h01);
    tick();
    check("irq_unmask", {31'd0, irq}, 32'h1);
    bus_write(3'd3, 32'h01);
    tick();
    check("irq_w1c", {31'd0, irq}, 32'h0);
    read_expect(3'd3, 32'h0, "w1c_clear");

    // Rising-only, exact latency to readback.
    bus_write(3'd4, 32'h1F);
    bus_write(3'd5, 32'h00);
    in_port = 5'b00100; address = 3'd3;
    ticks(SYNC + 2);
    check("rise_early", readdata, 32'h0);
    tick();
    check("rise_latency", readdata, 32'h04);
    in_port = 5'b00000; ticks(10);
    read_expect(3'd3, 32'h04, "fall_ignored");
    bus_write(3'd3, 32'h04);

    // Debounce period 4: 3-cycle glitch rejected, 5-cycle pulse accepted.
    bus_write(3'd6, 32'd4);
    in_port = 5'b00001; ticks(3);
    in_port = 5'b00000; ticks(10);
    read_expect(3'd0, 32'h0, "glitch_stable");
    read_expect(3'd3, 32'h0, "glitch_nocap");
    in_port = 5'b00001; ticks(5);
    in_port = 5'b00000; ticks(15);
    read_expect(3'd3, 32'h01, "pulse_cap");
    bus_write(3'd3, 32'h01);
    bus_write(3'd6, 32'd0);

    // Edge and W1C of the same bit on the same clock: the set wins.
    in_port = 5'b00010;
    ticks(3);
    bus_write(3'd3, 32'h02);
    read_expect(3'd3, 32'h02, "set_wins");
    in_port = 5'b00000;
    bus_write(3'd3, 32'h00);
    read_expect(3'd3, 32'h02, "w1c_zero");

    // Register map checks.
    read_expect(3'd7, 32'h0, "reserved");
    bus_write(3'd2, 32'hFFFF_FFFF);
    read_expect(3'd2, 32'h1F, "mask_trunc");
    bus_write(3'd0, 32'hFFFF_FFFF);
    read_expect(3'd0, 32'h0, "ro_write");
    bus_write(3'd6, 32'hABCD_1234);
    read_expect(3'd6, 32'h1234, "deb_trunc");
    address = 3'd4;
    check("rd_hold", readdata, 32'h1234);
    tick();
    check("rd_latency", readdata, 32'h1F);

    // Reset in the middle of a debounce with all capture bits set.
    bus_write(3'd6, 32'd10);
    in_port = 5'b11111; ticks(20);
    read_expect(3'd3, 32'h1F, "edge_all");
    check("irq_all", {31'd0, irq}, 32'h1);
    in_port = 5'b00000; ticks(5);
    reset = 1'b1; ticks(2);
    check("mid_rst_rd", readdata, 32'h0);
    check("mid_rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0; ticks(20);
    read_expect(3'd3, 32'h0, "post_rst_edge");
    read_expect(3'd5, 32'h1F, "post_rst_fall");
    read_expect(3'd6, 32'h0, "post_rst_deb");
    read_expect(3'd2, 32'h0, "post_rst_mask");
    read_expect(3'd4, 32'h0, "post_rst_rise");
    check("post_rst_irq", {31'd0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
